// File: rtl/tick_divider.sv
// tick_divider: programmable tick generator with double-buffered limit,
// mid-period half tick and periodic/one-shot operation.
module tick_divider #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEFAULT_LIMIT = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enabled,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             oneshot,
    output logic             overflow,
    output logic             half,
    output logic [WIDTH-1:0] value,
    output logic             pending,
    output logic             done
);

    localparam logic [WIDTH-1:0] RST_LIMIT = WIDTH'(DEFAULT_LIMIT);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_active_limit;
    logic [WIDTH-1:0] r_shadow_limit;
    logic             r_pending;
    logic             r_done;

    logic [WIDTH-1:0] w_value_nxt;
    logic [WIDTH-1:0] w_active_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             w_pending_nxt;
    logic             w_done_nxt;

    logic             w_count_en;
    logic             w_wrap;
    logic             w_mid;
    logic             w_idle;
    logic             w_apply;

    // Tick decode from registered state and the live enable
    always_comb begin
        w_count_en = enabled & ~r_done;
        w_wrap     = w_count_en & (r_value == r_active_limit);
        w_mid      = w_count_en & (r_value == (r_active_limit >> 1));
        w_idle     = (r_value == '0) & ~enabled;
        // Safe points to swap in a new limit: never mid-period
        w_apply    = w_wrap | clear | w_idle;
    end

    // Next-state for counter, done flag and the two limit registers
    always_comb begin
        w_value_nxt   = r_value;
        w_done_nxt    = r_done;
        w_active_nxt  = r_active_limit;
        w_shadow_nxt  = r_shadow_limit;
        w_pending_nxt = r_pending;

        if (clear) begin
            w_value_nxt = '0;
            w_done_nxt  = 1'b0;
        end else if (w_count_en) begin
            if (w_wrap) begin
                w_value_nxt = '0;
                if (oneshot) begin
                    w_done_nxt = 1'b1;
                end
            end else begin
                w_value_nxt = r_value + WIDTH'(1);
            end
        end

        if (load) begin
            w_shadow_nxt = limit_in;
            if (w_apply) begin
                // Load at a safe point bypasses the shadow stage
                w_active_nxt  = limit_in;
                w_pending_nxt = 1'b0;
            end else begin
                w_pending_nxt = 1'b1;
            end
        end else if (w_apply && r_pending) begin
            w_active_nxt  = r_shadow_limit;
            w_pending_nxt = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value        <= '0;
            r_active_limit <= RST_LIMIT;
            r_shadow_limit <= RST_LIMIT;
            r_pending      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_value        <= w_value_nxt;
            r_active_limit <= w_active_nxt;
            r_shadow_limit <= w_shadow_nxt;
            r_pending      <= w_pending_nxt;
            r_done         <= w_done_nxt;
        end
    end

    // Ticks are suppressed while reset is held
    assign overflow = w_wrap & ~rst;
    assign half     = w_mid & ~rst;
    assign value    = r_value;
    assign pending  = r_pending;
    assign done     = r_done;

endmodule
